// File: rtl/fpu_op_seq.sv
// Operation sequencer and result-capture stage in front of the FPU result mux.
// Selects the mux path, starts or waits on the slow units, and holds the result until it is consumed.
module fpu_op_seq #(
    parameter int MUL_LAT   = 3,
    parameter int TO_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  funct5,
    input  logic        flush,
    output logic [4:0]  sel,
    output logic        div_start,
    output logic        sqrt_start,
    output logic        unit_abort,
    input  logic        div_done,
    input  logic        sqrt_done,
    input  logic [31:0] mux_result,
    input  logic        mux_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_ovf,
    output logic        out_err,
    output logic        out_illegal
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WAIT, ST_HOLD} state_t;
    typedef enum logic [1:0] {K_COMB, K_MUL, K_DIV, K_SQRT} kind_t;

    localparam logic [7:0] MUL_INIT = 8'(MUL_LAT - 1);
    localparam logic [7:0] TO_LAST  = 8'(TO_CYCLES - 1);

    function automatic logic is_legal(input logic [4:0] f);
        case (f)
            5'b00000, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00101, 5'b01011, 5'b10100,
            5'b11000, 5'b11010, 5'b11100, 5'b11110: is_legal = 1'b1;
            default:                                is_legal = 1'b0;
        endcase
    endfunction

    function automatic kind_t decode_kind(input logic [4:0] f);
        case (f)
            5'b00010: decode_kind = K_MUL;
            5'b00011: decode_kind = K_DIV;
            5'b01011: decode_kind = K_SQRT;
            default:  decode_kind = K_COMB;
        endcase
    endfunction

    state_t      state_r;
    kind_t       kind_r;
    logic [7:0]  cnt_r;
    logic        illegal_r;

    logic        in_ready_s;
    logic        accept_s;
    logic        done_s;
    kind_t       new_kind_s;

    // Handshake, decode and the done input that matches the running unit
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        done_s     = 1'b0;
        new_kind_s = decode_kind(funct5);
        if (flush) begin
            in_ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == ST_HOLD && out_ready) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
        if (kind_r == K_DIV) begin
            done_s = div_done;
        end else if (kind_r == K_SQRT) begin
            done_s = sqrt_done;
        end else begin
            done_s = 1'b0;
        end
    end

    assign in_ready = in_ready_s;

    // Sequencer state, counters, unit pulses and result capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            kind_r      <= K_COMB;
            cnt_r       <= 8'd0;
            illegal_r   <= 1'b0;
            sel         <= 5'b00000;
            div_start   <= 1'b0;
            sqrt_start  <= 1'b0;
            unit_abort  <= 1'b0;
            out_valid   <= 1'b0;
            out_result  <= 32'd0;
            out_ovf     <= 1'b0;
            out_err     <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            div_start  <= 1'b0;
            sqrt_start <= 1'b0;
            unit_abort <= 1'b0;
            if (flush) begin
                state_r    <= ST_IDLE;
                out_valid  <= 1'b0;
                cnt_r      <= 8'd0;
                unit_abort <= (state_r == ST_WAIT);
            end else if (accept_s) begin
                sel       <= funct5;
                illegal_r <= ~is_legal(funct5);
                kind_r    <= new_kind_s;
                out_valid <= 1'b0;
                case (new_kind_s)
                    K_MUL: begin
                        state_r <= ST_EXEC;
                        cnt_r   <= MUL_INIT;
                    end
                    K_DIV: begin
                        state_r   <= ST_WAIT;
                        cnt_r     <= 8'd0;
                        div_start <= 1'b1;
                    end
                    K_SQRT: begin
                        state_r    <= ST_WAIT;
                        cnt_r      <= 8'd0;
                        sqrt_start <= 1'b1;
                    end
                    default: begin
                        state_r <= ST_EXEC;
                        cnt_r   <= 8'd0;
                    end
                endcase
            end else begin
                case (state_r)
                    ST_EXEC: begin
                        if (cnt_r != 8'd0) begin
                            cnt_r <= cnt_r - 8'd1;
                        end else begin
                            out_result  <= mux_result;
                            out_ovf     <= mux_ovf;
                            out_err     <= 1'b0;
                            out_illegal <= illegal_r;
                            out_valid   <= 1'b1;
                            state_r     <= ST_HOLD;
                        end
                    end
                    ST_WAIT: begin
                        // a done arriving on the timeout edge still delivers a real result
                        if (done_s) begin
                            out_result  <= mux_result;
                            out_ovf     <= mux_ovf;
                            out_err     <= 1'b0;
                            out_illegal <= illegal_r;
                            out_valid   <= 1'b1;
                            state_r     <= ST_HOLD;
                        end else if (cnt_r == TO_LAST) begin
                            out_result  <= 32'd0;
                            out_ovf     <= 1'b0;
                            out_err     <= 1'b1;
                            out_illegal <= illegal_r;
                            out_valid   <= 1'b1;
                            state_r     <= ST_HOLD;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    ST_HOLD: begin
                        if (out_ready) begin
                            state_r   <= ST_IDLE;
                            out_valid <= 1'b0;
                        end else begin
                            state_r <= ST_HOLD;
                        end
                    end
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_op_seq.sv
// Self-checking bench for fpu_op_seq: directed scenarios followed by random operations
// compared against a latency/outcome reference model.
module tb_fpu_op_seq;

    localparam int MUL_LAT   = 3;
    localparam int TO_CYCLES = 8;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  funct5;
    logic        flush;
    logic [4:0]  sel;
    logic        div_start;
    logic        sqrt_start;
    logic        unit_abort;
    logic        div_done;
    logic        sqrt_done;
    logic [31:0] mux_result;
    logic        mux_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_err;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] legal_codes [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                     5'b00100, 5'b00101, 5'b01011, 5'b10100,
                                     5'b11000, 5'b11010, 5'b11100, 5'b11110};

    fpu_op_seq #(.MUL_LAT(MUL_LAT), .TO_CYCLES(TO_CYCLES)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .funct5(funct5), .flush(flush), .sel(sel), .div_start(div_start),
        .sqrt_start(sqrt_start), .unit_abort(unit_abort), .div_done(div_done),
        .sqrt_done(sqrt_done), .mux_result(mux_result), .mux_ovf(mux_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ovf(out_ovf), .out_err(out_err), .out_illegal(out_illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [4:0] f);
        foreach (legal_codes[i]) if (legal_codes[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    // cycles from accept edge to out_valid; d = cycle of matching done (0 = never)
    function automatic int ref_latency(input logic [4:0] f, input int d);
        if (f == 5'b00010) return MUL_LAT;
        if (f == 5'b00011 || f == 5'b01011) return (d != 0 && d <= TO_CYCLES) ? d : TO_CYCLES;
        return 1;
    endfunction

    task automatic run_op(input logic [4:0] f, input logic [31:0] res, input logic ovf,
                          input int d, input int w, input int h);
        bit          is_div  = (f == 5'b00011);
        bit          is_sqrt = (f == 5'b01011);
        int          lat     = ref_latency(f, d);
        bit          tmo     = (is_div || is_sqrt) && !(d != 0 && d <= TO_CYCLES);
        logic [31:0] exp_res = tmo ? 32'd0 : res;
        logic        exp_ovf = tmo ? 1'b0 : ovf;
        out_ready  = 1'b0;
        funct5     = f;
        mux_result = res;
        mux_ovf    = ovf;
        in_valid   = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        funct5   = 5'($urandom);
        chk("sel_accept", sel, f);
        chk("div_start_pulse", div_start, is_div);
        chk("sqrt_start_pulse", sqrt_start, is_sqrt);
        for (int k = 1; k <= lat; k++) begin
            div_done  = is_div  ? (k == d) : (k == w);
            sqrt_done = is_sqrt ? (k == d) : (k == w);
            tick();
            chk("out_valid_timing", out_valid, (k == lat));
            chk("starts_low", {div_start, sqrt_start}, 0);
        end
        div_done   = 1'b0;
        sqrt_done  = 1'b0;
        mux_result = $urandom;
        mux_ovf    = 1'($urandom);
        chk("out_result", out_result, exp_res);
        chk("out_ovf", out_ovf, exp_ovf);
        chk("out_err", out_err, tmo);
        chk("out_illegal", out_illegal, !ref_legal(f));
        chk("sel_hold", sel, f);
        for (int i = 0; i < h; i++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, exp_res);
            chk("hold_err", out_err, tmo);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("consumed_valid", out_valid, 0);
        chk("consumed_in_ready", in_ready, 1);
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; funct5 = 5'd0; flush = 1'b0;
        div_done = 1'b0; sqrt_done = 1'b0; mux_result = 32'd0; mux_ovf = 1'b0;
        out_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_flags", {out_ovf, out_err, out_illegal}, 0);
        chk("rst_pulses", {div_start, sqrt_start, unit_abort}, 0);
        chk("rst_sel", sel, 0);
        RST = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // COMB back-to-back with out_ready tied high
        out_ready = 1'b1; in_valid = 1'b1; funct5 = 5'b00000;
        mux_result = 32'h12345678; mux_ovf = 1'b0;
        tick();
        chk("b2b_first_pending", out_valid, 0);
        funct5 = 5'b10100;
        tick();
        chk("b2b_first_valid", out_valid, 1);
        chk("b2b_first_result", out_result, 32'h12345678);
        chk("b2b_hold_in_ready", in_ready, 1);
        mux_result = 32'hCAFEF00D;
        tick();
        chk("b2b_second_accept", out_valid, 0);
        chk("b2b_sel", sel, 5'b10100);
        in_valid = 1'b0;
        tick();
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_result", out_result, 32'hCAFEF00D);
        tick();
        chk("b2b_drain", out_valid, 0);
        out_ready = 1'b0;

        // MUL latency, DIV with early sqrt_done, SQRT timeout with backpressure, illegal code
        run_op(5'b00010, 32'h3F800000, 1'b1, 0, 1, 0);
        run_op(5'b00011, 32'h40490FDB, 1'b0, 5, 2, 1);
        run_op(5'b01011, 32'hDEADBEEF, 1'b1, 0, 3, 4);
        run_op(5'b01011, 32'h11223344, 1'b1, TO_CYCLES, 1, 0);
        run_op(5'b01111, 32'h0BADF00D, 1'b0, 0, 1, 1);

        // flush during WAIT
        in_valid = 1'b1; funct5 = 5'b00011;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_valid", out_valid, 0);
        chk("flush_abort", unit_abort, 1);
        chk("flush_idle", in_ready, 1);
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        chk("flush_abort_once", unit_abort, 0);
        chk("flush_no_capture", out_valid, 0);

        // reset in the middle of a multiply and of a divide
        in_valid = 1'b1; funct5 = 5'b00010; mux_result = 32'h55AA55AA;
        tick();
        in_valid = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        chk("mid_rst_outputs", {out_valid, out_ovf, out_err, out_illegal}, 0);
        chk("mid_rst_result", out_result, 0);
        chk("mid_rst_sel", sel, 0);
        RST = 1'b0;
        in_valid = 1'b1; funct5 = 5'b00011;
        tick();
        in_valid = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("wait_rst_pulses", {div_start, sqrt_start, unit_abort}, 0);
        #1;
        chk("wait_rst_in_ready", in_ready, 1);

        // random operations
        for (int n = 0; n < 40; n++) begin
            logic [4:0] f;
            case ($urandom_range(3, 0))
                0:       f = ($urandom_range(1, 0) == 1) ? 5'b00011 : 5'b01011;
                1:       f = 5'($urandom);
                default: f = legal_codes[$urandom_range(11, 0)];
            endcase
            run_op(f, $urandom, 1'($urandom), $urandom_range(TO_CYCLES + 2, 0),
                   $urandom_range(4, 1), $urandom_range(3, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
